// File: rtl/rx_frame_controller_pkg.sv
// ============================================================================
// rx_frame_controller_pkg : receive-path state encodings and default sizing
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_frame_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

endpackage

`default_nettype wire

// File: rtl/rx_frame_controller_sync.sv
// ============================================================================
// rx_frame_controller_sync : two-flop synchroniser for the raw serial line
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_controller_sync (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   output logic rx_s
);

   logic meta;

   // Reset to the idle (mark) level so no false start is seen out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         meta <= data_in;
         rx_s <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rx_frame_controller.sv
// ============================================================================
// rx_frame_controller : oversampled serial receive sequencer with holding reg
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_controller
   import rx_frame_controller_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_in,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 char_received,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             PAR_INIT  = (PARITY_ODD != 0);

   rx_state_t              state;
   rx_state_t              state_nxt;
   logic                   rx_s;
   logic                   armed;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shift;
   logic                   par_acc;
   logic                   bad_par;

   logic                   start_ok;
   logic                   data_sample;
   logic                   par_sample;
   logic                   stop_sample;
   logic                   load_good;
   logic                   cnt_clear;

   rx_frame_controller_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .rx_s    (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      start_ok    = 1'b0;
      data_sample = 1'b0;
      par_sample  = 1'b0;
      stop_sample = 1'b0;
      cnt_clear   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clear = 1'b1;
            if (armed && !rx_s) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_clear = 1'b1;
               start_ok  = !rx_s;
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_clear   = 1'b1;
               data_sample = 1'b1;
               if (bit_idx == IDX_LAST) begin
                  state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_clear  = 1'b1;
               par_sample = 1'b1;
               state_nxt  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_clear   = 1'b1;
               stop_sample = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            cnt_clear = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
      load_good = stop_sample && rx_s && !bad_par;
   end

   assign busy = (state != ST_IDLE);

   // Sequencing datapath: bit counter, shift register and parity tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed   <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par_acc <= 1'b0;
         bad_par <= 1'b0;
      end else begin
         if (rx_s) begin
            armed <= 1'b1;
         end
         cnt <= cnt_clear ? '0 : cnt + CNT_W'(1);
         if (start_ok) begin
            bit_idx <= '0;
            par_acc <= PAR_INIT;
            bad_par <= 1'b0;
         end
         if (data_sample) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            par_acc <= par_acc ^ rx_s;
            bit_idx <= bit_idx + IDX_W'(1);
         end
         if (par_sample) begin
            bad_par <= par_acc ^ rx_s;
         end
      end
   end

   // Holding register: a fresh load beats a coincident acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         overrun       <= 1'b0;
         char_received <= 1'b0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         char_received <= load_good;
         parity_err    <= stop_sample && rx_s && bad_par;
         frame_err     <= stop_sample && !rx_s;
         if (load_good) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            if (rx_valid) begin
               overrun <= !rx_ack;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_controller.sv
// ============================================================================
// tb_rx_frame_controller : vector table, directed corner cases, random frames
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_controller;

   localparam int OS  = 16;
   localparam int LAT = 171;   // data_in fall cycle to char_received cycle
   localparam int STOP_CYC = 170;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       data_in = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       char_received;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   rx_frame_controller dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .rx_ack        (rx_ack),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .char_received (char_received),
      .parity_err    (parity_err),
      .frame_err     (frame_err),
      .overrun       (overrun),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chr = 0, n_perr = 0, n_ferr = 0, n_excl = 0, chr_cyc = 0;
   always @(negedge clk) begin
      if (reset) begin
         if (char_received) begin
            n_chr   <= n_chr + 1;
            chr_cyc <= cyc;
         end
         if (parity_err) n_perr <= n_perr + 1;
         if (frame_err)  n_ferr <= n_ferr + 1;
         if (char_received && (parity_err || frame_err)) n_excl <= n_excl + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model of the holding register, kept at transaction level
   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;

   task automatic model_ack();
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic do_frame(input logic [7:0] d, input bit pb, input bit sb,
                           input bit ack_before, input int ack_at,
                           input bit e_chr, input bit e_perr, input bit e_ferr,
                           input logic [7:0] e_data, input bit e_valid, input bit e_ovr,
                           input string tag);
      int          c0, p0, f0, start;
      logic [10:0] bits;
      if (ack_before) begin
         rx_ack = 1'b1;
         tick();
         rx_ack = 1'b0;
      end
      bits  = {sb, pb, d, 1'b0};
      c0    = n_chr;
      p0    = n_perr;
      f0    = n_ferr;
      start = cyc;
      for (int i = 0; i < 11 * OS; i++) begin
         data_in = bits[i / OS];
         rx_ack  = (i == ack_at);
         tick();
      end
      data_in = 1'b1;
      rx_ack  = 1'b0;
      tick(4);
      check({tag, " char_received count"}, n_chr - c0, {31'd0, e_chr});
      check({tag, " parity_err count"}, n_perr - p0, {31'd0, e_perr});
      check({tag, " frame_err count"}, n_ferr - f0, {31'd0, e_ferr});
      check({tag, " rx_data"}, rx_data, e_data);
      check({tag, " rx_valid"}, rx_valid, e_valid);
      check({tag, " overrun"}, overrun, e_ovr);
      check({tag, " busy idle"}, busy, 0);
      if (e_chr) check({tag, " latency"}, chr_cyc - start, LAT);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         pb;
      bit         sb;
      bit         ack_before;
      int         ack_at;
      bit         e_chr;
      bit         e_perr;
      bit         e_ferr;
      logic [7:0] e_data;
      bit         e_valid;
      bit         e_ovr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int         c0, p0, f0, start;
      logic [7:0] d;
      bit         wrong, pb, sb, ab, same, good;
      int         aa;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, -1,       1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, -1,       1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, -1,       1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, -1,       1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, -1,       1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
      vecs[5] = '{8'h11, 1'b0, 1'b1, 1'b0, -1,       1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
      vecs[6] = '{8'h22, 1'b0, 1'b1, 1'b0, -1,       1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
      vecs[7] = '{8'h33, 1'b0, 1'b1, 1'b0, STOP_CYC, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0};

      // Reset state
      tick(3);
      check("reset outputs", {rx_data, rx_valid, overrun, busy, char_received, parity_err, frame_err}, 0);
      reset = 1'b1;
      tick(3);
      check("post-reset busy", busy, 0);

      for (int i = 0; i < 8; i++) begin
         do_frame(vecs[i].d, vecs[i].pb, vecs[i].sb, vecs[i].ack_before, vecs[i].ack_at,
                  vecs[i].e_chr, vecs[i].e_perr, vecs[i].e_ferr,
                  vecs[i].e_data, vecs[i].e_valid, vecs[i].e_ovr, $sformatf("vec%0d", i));
      end

      // Acknowledge clears valid and overrun; a second ack with nothing held is ignored
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      check("ack rx_valid", rx_valid, 0);
      check("ack overrun", overrun, 0);
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      tick();
      check("idle ack rx_valid", rx_valid, 0);
      check("idle ack rx_data", rx_data, 8'h33);

      do_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, "pre-reset");

      // Reset asserted mid-frame
      c0 = n_chr;
      data_in = 1'b0;
      tick(60);
      reset = 1'b0;
      tick();
      check("mid-frame reset outputs",
            {rx_data, rx_valid, overrun, busy, char_received, parity_err, frame_err}, 0);
      data_in = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(200);
      check("mid-frame reset no char", n_chr - c0, 0);
      check("mid-frame reset busy", busy, 0);
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;

      // Four-cycle glitch is rejected as a false start
      c0 = n_chr;
      p0 = n_perr;
      f0 = n_ferr;
      start = cyc;
      data_in = 1'b0;
      tick(4);
      data_in = 1'b1;
      tick();
      check("glitch busy asserted", busy, 1);
      tick(start + 11 - cyc);
      check("glitch busy released", busy, 0);
      tick(200);
      check("glitch no flags", (n_chr - c0) + (n_perr - p0) + (n_ferr - f0), 0);
      check("glitch rx_valid", rx_valid, 0);

      // Random frames against the transaction-level model
      for (int k = 0; k < 24; k++) begin
         d     = 8'($urandom);
         wrong = ($urandom_range(0, 4) == 0);
         pb    = (^d) ^ wrong;
         sb    = ($urandom_range(0, 5) != 0);
         ab    = 1'($urandom_range(0, 1));
         aa    = ($urandom_range(0, 7) == 0) ? STOP_CYC : -1;
         same  = (aa == STOP_CYC);
         good  = sb && !wrong;
         if (ab) model_ack();
         if (good) begin
            if (m_valid) m_ovr = !same;
            m_valid = 1'b1;
            m_data  = d;
         end else if (same) begin
            model_ack();
         end
         do_frame(d, pb, sb, ab, aa, good, sb && wrong, !sb,
                  m_data, m_valid, m_ovr, $sformatf("rand%0d", k));
      end

      check("char/error exclusivity", n_excl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
